// File: rtl/vending_pkg.sv
// vending_pkg: shared constants, coin decode and FSM state type for the coin credit accumulator
// Holds coin codes and values, the credit width and default ceiling, and the IDLE/REQ/REFUND state enum.
package vending_pkg;
  localparam int CREDIT_W = 8;
  localparam int CREDIT_MAX_DEF = 99;
  localparam logic [3:0] COIN_CODE_1 = 4'd1;
  localparam logic [3:0] COIN_CODE_5 = 4'd2;
  localparam logic [3:0] COIN_CODE_10 = 4'd3;
  localparam logic [3:0] COIN_CODE_20 = 4'd4;
  localparam logic [CREDIT_W-1:0] COIN_VAL_1 = 8'd1;
  localparam logic [CREDIT_W-1:0] COIN_VAL_5 = 8'd5;
  localparam logic [CREDIT_W-1:0] COIN_VAL_10 = 8'd10;
  localparam logic [CREDIT_W-1:0] COIN_VAL_20 = 8'd20;
  typedef enum logic [1:0] {IDLE, REQ, REFUND} state_e;
  // A value of zero marks an invalid code.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic [3:0] code);
    return code == COIN_CODE_1  ? COIN_VAL_1  :
           code == COIN_CODE_5  ? COIN_VAL_5  :
           code == COIN_CODE_10 ? COIN_VAL_10 :
           code == COIN_CODE_20 ? COIN_VAL_20 : '0;
  endfunction
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: 2-flop synchronizer, optional debounce counter and rising-edge detector for one raw button
// Ports: clk, rst_n (async active-low), btn_i (raw button), press_o (one-cycle registered press pulse).
// Macro COIN_DEBOUNCE_EN: when defined, the level must hold DEBOUNCE_CYCLES cycles before being accepted.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);
  logic sync1_q, sync2_q, prev_q, press_q, level;
`ifdef COIN_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic stable_q, stable_d;
  // Counter only runs while the synchronized level disagrees with the accepted one.
  always_comb begin
    cnt_d = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) stable_d = sync2_q;
      else cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      stable_q <= stable_d;
    end
  end
  assign level = stable_q;
`else
  assign level = sync2_q;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      prev_q <= level;
      press_q <= level & ~prev_q;
    end
  end
  assign press_o = press_q;
endmodule

// File: rtl/coin_credit_accumulator.sv
// coin_credit_accumulator: accumulates coin credit, issues vend requests and refunds from three raw buttons
// Ports: clk, rst_n (async active-low); coin_insert_button, confirm_button, refund_button (raw);
//   coin_code (denomination); credit, coin_reject; vend_req, vend_credit, vend_ack, vend_ok, vend_spent;
//   refund_valid, refund_amount.
// Macro COIN_DEBOUNCE_EN: enables the debounce counters inside each button_debouncer.
module coin_credit_accumulator
  import vending_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CREDIT_MAX = CREDIT_MAX_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin_insert_button,
  input  logic                confirm_button,
  input  logic                refund_button,
  input  logic [3:0]          coin_code,
  output logic [CREDIT_W-1:0] credit,
  output logic                coin_reject,
  output logic                vend_req,
  output logic [CREDIT_W-1:0] vend_credit,
  input  logic                vend_ack,
  input  logic                vend_ok,
  input  logic [CREDIT_W-1:0] vend_spent,
  output logic                refund_valid,
  output logic [CREDIT_W-1:0] refund_amount
);
  localparam logic [CREDIT_W:0] CMAX = (CREDIT_W+1)'(CREDIT_MAX);
  logic coin_p, conf_p, ref_p;
  state_e state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d, vcred_q, vcred_d, val;
  logic [CREDIT_W:0] sum;
  logic reject_q, reject_d;
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_coin (
    .clk(clk), .rst_n(rst_n), .btn_i(coin_insert_button), .press_o(coin_p));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_conf (
    .clk(clk), .rst_n(rst_n), .btn_i(confirm_button), .press_o(conf_p));
  button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ref (
    .clk(clk), .rst_n(rst_n), .btn_i(refund_button), .press_o(ref_p));
  assign val = coin_value(coin_code);
  assign sum = {1'b0, credit_q} + {1'b0, val};
  // A refund press always wins in IDLE, so a coming-along coin or confirm press is dropped.
  always_comb begin
    state_d = state_q;
    credit_d = credit_q;
    vcred_d = vcred_q;
    reject_d = 1'b0;
    case (state_q)
      IDLE:
        if (ref_p) state_d = credit_q != '0 ? REFUND : IDLE;
        else if (coin_p) begin
          if (val != '0 && sum <= CMAX) credit_d = sum[CREDIT_W-1:0];
          else reject_d = 1'b1;
        end else if (conf_p && credit_q != '0) begin
          state_d = REQ;
          vcred_d = credit_q;
        end
      REQ: begin
        reject_d = coin_p;
        if (vend_ack) begin
          state_d = IDLE;
          if (vend_ok) credit_d = credit_q > vend_spent ? credit_q - vend_spent : '0;
        end
      end
      REFUND: begin
        state_d = IDLE;
        credit_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      credit_q <= '0;
      vcred_q <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q <= state_d;
      credit_q <= credit_d;
      vcred_q <= vcred_d;
      reject_q <= reject_d;
    end
  end
  assign credit = credit_q;
  assign coin_reject = reject_q;
  assign vend_req = state_q == REQ;
  assign vend_credit = vcred_q;
  assign refund_valid = state_q == REFUND;
  assign refund_amount = refund_valid ? credit_q : '0;
endmodule

// File: doc/coin_credit_accumulator.md
COIN_CREDIT_ACCUMULATOR -- requirements
Module: coin_credit_accumulator

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, the number of stable clk cycles before a button level is accepted (20 ms at 50 MHz).
REQ-002 Parameter CREDIT_MAX, default 99, the credit saturation ceiling (two display digits).
REQ-003 clk  in  1  system clock; one clock domain, all logic on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous and active-low.
REQ-005 coin_insert_button  in  1  raw, bouncy coin-insert button.
REQ-006 confirm_button  in  1  raw, bouncy purchase-confirm button.
REQ-007 refund_button  in  1  raw, bouncy refund button.
REQ-008 coin_code  in  4  coin denomination code, sampled on the accepted coin press.
REQ-009 credit  out  8  current credit, binary, range 0..CREDIT_MAX.
REQ-010 coin_reject  out  1  one-cycle pulse when a coin is refused.
REQ-011 vend_req  out  1  purchase request to the controller; stays high until acknowledged.
REQ-012 vend_credit  out  8  credit snapshot; held stable while vend_req=1.
REQ-013 vend_ack  in  1  one-cycle acknowledge from the controller.
REQ-014 vend_ok  in  1  qualifies vend_ack: 1 = sold, 0 = refused.
REQ-015 vend_spent  in  8  amount consumed; valid with vend_ack && vend_ok.
REQ-016 refund_valid  out  1  one-cycle pulse when credit is returned.
REQ-017 refund_amount  out  8  amount returned; valid with refund_valid, otherwise 0.

Function
REQ-018 Each button SHALL pass through a 2-flop synchronizer, then debounce, then a rising-edge detector, producing a one-cycle press pulse.
REQ-019 Press latency SHALL be 2 + DEBOUNCE_CYCLES + 1 cycles from a stable raw edge.
REQ-020 Coin values SHALL be decoded as: code 1 = 1, 2 = 5, 3 = 10, 4 = 20; every other code is invalid.
REQ-021 FSM states SHALL be IDLE, REQ and REFUND.
REQ-022 In IDLE, a coin press with a valid code and credit+value <= CREDIT_MAX SHALL add the value to credit on the next cycle.
REQ-023 In IDLE, a coin press with an invalid code or an overflowing sum SHALL pulse coin_reject and leave credit unchanged.
REQ-024 In IDLE, a confirm press with credit > 0 SHALL move to REQ, assert vend_req and load vend_credit = credit.
REQ-025 A confirm press with credit = 0 SHALL be ignored.
REQ-026 In REQ, credit and vend_credit SHALL be frozen.
REQ-027 In REQ, every coin press SHALL pulse coin_reject, and refund presses SHALL be ignored.
REQ-028 In REQ, vend_ack && vend_ok SHALL set credit = credit - vend_spent (clamped at 0), drop vend_req and return to IDLE.
REQ-029 In REQ, vend_ack && !vend_ok SHALL drop vend_req and return to IDLE with credit unchanged.
REQ-030 In IDLE, a refund press with credit > 0 SHALL go to REFUND.
REQ-031 REFUND SHALL last one cycle: pulse refund_valid with refund_amount = credit, clear credit, then return to IDLE.
REQ-032 For simultaneous presses in IDLE, priority SHALL be refund > coin > confirm; any lower-priority press is dropped.
REQ-033 vend_ack outside REQ SHALL be ignored.

Reset
REQ-034 On rst_n=0 the block SHALL immediately enter IDLE with credit, vend_credit and refund_amount = 0, all pulses and vend_req = 0, and synchronizers and debouncers cleared.
REQ-035 A reset during REQ SHALL drop vend_req without waiting for an acknowledge.

Configuration
REQ-036 With COIN_DEBOUNCE_EN defined, the debouncer of REQ-018 SHALL be instantiated.
REQ-037 Without COIN_DEBOUNCE_EN, the synchronizer output SHALL drive the edge detector directly, giving a 3-cycle press latency; this is the simulation setting.

Structure
REQ-038 Package vending_pkg SHALL hold the coin code constants, coin values, CREDIT_MAX default, the credit width (8) and the FSM state enum.
REQ-039 Sub-module button_debouncer SHALL contain one synchronizer, debounce counter and edge detector, and SHALL be instantiated three times.

Verification
REQ-040 Reset, then coins 2, 3, 4 -> credit reaches 5, 15, 35; no coin_reject.
REQ-041 Credit 95, then coin code 3 -> coin_reject pulse, credit stays 95; coin code 7 -> coin_reject, credit unchanged.
REQ-042 Credit 35, confirm; ack with vend_ok=1 and vend_spent=15 -> vend_credit=35 held while vend_req=1, then credit=20 and vend_req=0.
REQ-043 In REQ, insert a coin and press refund, then ack with vend_ok=0 -> coin_reject pulse, no refund, credit stays 35.
REQ-044 Credit 20, refund and coin pressed in the same cycle -> refund_valid with refund_amount=20, credit=0, coin dropped.
REQ-045 rst_n low mid-REQ -> vend_req and credit are 0 asynchronously; without COIN_DEBOUNCE_EN, press latency is exactly 3 cycles.
